// File: rtl/lfsr_gen.sv
// Fibonacci LFSR pseudo-random source with runtime seed load and lock-up recovery.
// Optional period counter enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] dout,
    output logic             lockup,
    output logic [WIDTH-1:0] period_cnt,
    output logic             period_wrap
);

    // STEP single shifts chained combinationally; feedback enters at the MSB.
    function automatic logic [WIDTH-1:0] shift_n(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int unsigned i = 0; i < STEP; i++) begin
            v = {^(v & TAPS), v[WIDTH-1:1]};
        end
        return v;
    endfunction

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] dout_nxt;
    logic             lockup_nxt;

    assign stepped = shift_n(dout);

    // Priority: load > lock-up recovery > en > hold.
    always_comb begin
        dout_nxt   = dout;
        lockup_nxt = 1'b0;
        if (load) begin
            if (seed_in != '0) begin
                dout_nxt = seed_in;
            end else begin
                dout_nxt   = SEED;
                lockup_nxt = 1'b1;
            end
        end else if (dout == '0) begin
            dout_nxt   = SEED;
            lockup_nxt = 1'b1;
        end else if (en) begin
            dout_nxt = stepped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= SEED;
            lockup <= 1'b0;
        end else begin
            dout   <= dout_nxt;
            lockup <= lockup_nxt;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] active_seed;
    logic [WIDTH-1:0] cnt_q;
    logic             wrap_q;

    // Counts advances since the last (re)seed; wraps when the sequence returns to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_seed <= SEED;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (load) begin
                active_seed <= (seed_in != '0) ? seed_in : SEED;
                cnt_q       <= '0;
            end else if (dout == '0) begin
                active_seed <= SEED;
                cnt_q       <= '0;
            end else if (en) begin
                if (stepped == active_seed) begin
                    cnt_q  <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + WIDTH'(1);
                end
            end
        end
    end

    assign period_cnt  = cnt_q;
    assign period_wrap = wrap_q;
`else
    assign period_cnt  = '0;
    assign period_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen: default, STEP=2 and zero-tap instances.
// Period-counter checks follow LFSR_PERIOD_CNT_EN.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en_a = 1'b0, load_a = 1'b0;
    logic [7:0] seed_a = 8'h00;
    logic [7:0] dout_a, cnt_a;
    logic       lockup_a, wrap_a;

    logic       en_b = 1'b0, en_c = 1'b0;
    logic       load_z = 1'b0;
    logic [7:0] seed_z = 8'h00;
    logic [7:0] dout_b, cnt_b, dout_c, cnt_c;
    logic       lockup_b, wrap_b, lockup_c, wrap_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_gen u_dut (
        .clk(clk), .rst(rst), .en(en_a), .load(load_a), .seed_in(seed_a),
        .dout(dout_a), .lockup(lockup_a), .period_cnt(cnt_a), .period_wrap(wrap_a)
    );

    lfsr_gen #(.STEP(2)) u_step2 (
        .clk(clk), .rst(rst), .en(en_b), .load(load_z), .seed_in(seed_z),
        .dout(dout_b), .lockup(lockup_b), .period_cnt(cnt_b), .period_wrap(wrap_b)
    );

    lfsr_gen #(.TAPS(8'h00)) u_notap (
        .clk(clk), .rst(rst), .en(en_c), .load(load_z), .seed_in(seed_z),
        .dout(dout_c), .lockup(lockup_c), .period_cnt(cnt_c), .period_wrap(wrap_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] exp);
`ifdef LFSR_PERIOD_CNT_EN
        check(tag, 32'(cnt_a), 32'(exp));
`else
        check(tag, 32'(cnt_a), 32'h0);
`endif
    endtask

    initial begin
        logic [7:0] seq [5];
        int reps;
        int wraps;
        seq[0] = 8'h80; seq[1] = 8'h40; seq[2] = 8'h20; seq[3] = 8'h10; seq[4] = 8'h88;

        // reset state
        tick;
        tick;
        check("rst_dout", 32'(dout_a), 32'h01);
        check("rst_lockup", 32'(lockup_a), 32'h0);
        check("rst_cnt", 32'(cnt_a), 32'h0);
        check("rst_wrap", 32'(wrap_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // default sequence
        en_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("seq_%0d", i), 32'(dout_a), 32'(seq[i]));
        end
        check("seq_lockup", 32'(lockup_a), 32'h0);
        check_cnt("seq_cnt", 8'd5);
        en_a = 1'b0;
        tick;
        check("hold_dout", 32'(dout_a), 32'h88);
        check_cnt("hold_cnt", 8'd5);

        // full period from seed 01
        load_a = 1'b1; seed_a = 8'h01;
        tick;
        check("reload_dout", 32'(dout_a), 32'h01);
        check_cnt("reload_cnt", 8'd0);
        load_a = 1'b0; en_a = 1'b1;
        reps = 0; wraps = 0;
        for (int i = 1; i <= 255; i++) begin
            tick;
            if (i < 255 && dout_a == 8'h01) reps++;
            if (wrap_a) wraps++;
            if (i == 100) check_cnt("period_mid_cnt", 8'd100);
        end
        check("period_dout", 32'(dout_a), 32'h01);
        check("period_no_early", 32'(reps), 32'h0);
`ifdef LFSR_PERIOD_CNT_EN
        check("period_wraps", 32'(wraps), 32'h1);
`else
        check("period_wraps", 32'(wraps), 32'h0);
`endif
        check_cnt("period_cnt", 8'd0);
        en_a = 1'b0;
        tick;
        check("wrap_pulse_end", 32'(wrap_a), 32'h0);

        // load priority and zero seed
        load_a = 1'b1; seed_a = 8'h5A; en_a = 1'b1;
        tick;
        check("load_5a", 32'(dout_a), 32'h5A);
        check("load_5a_lockup", 32'(lockup_a), 32'h0);
        seed_a = 8'h00;
        tick;
        check("load_zero_dout", 32'(dout_a), 32'h01);
        check("load_zero_lockup", 32'(lockup_a), 32'h1);
        load_a = 1'b0; en_a = 1'b0;
        tick;
        check("lockup_one_cycle", 32'(lockup_a), 32'h0);
        check("load_zero_hold", 32'(dout_a), 32'h01);

        // STEP=2
        en_b = 1'b1;
        tick;
        check("step2_a", 32'(dout_b), 32'h40);
        tick;
        check("step2_b", 32'(dout_b), 32'h10);
        en_b = 1'b0;

        // zero taps: shifts into all-zero, then recovers
        en_c = 1'b1;
        tick;
        check("notap_zero", 32'(dout_c), 32'h00);
        check("notap_zero_lockup", 32'(lockup_c), 32'h0);
        tick;
        check("notap_recover", 32'(dout_c), 32'h01);
        check("notap_lockup", 32'(lockup_c), 32'h1);
        en_c = 1'b0;
        tick;
        check("notap_lockup_end", 32'(lockup_c), 32'h0);

        // async reset mid-run clears state and counter
        en_a = 1'b1;
        tick; tick; tick;
        check("pre_rst_dout", 32'(dout_a), 32'h20);
        check_cnt("pre_rst_cnt", 8'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dout", 32'(dout_a), 32'h01);
        check("async_rst_cnt", 32'(cnt_a), 32'h0);
        @(negedge clk);
        rst = 1'b0; en_a = 1'b0;

        // async reset kills a lockup pulse
        load_a = 1'b1; seed_a = 8'h00;
        tick;
        check("pre_rst_lockup", 32'(lockup_a), 32'h1);
        load_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_lockup", 32'(lockup_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
